// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin scheduler that shares one UART transmit line among N_REQ
//   byte requesters. It grants one requester at a time, latches that
//   requester's byte, and sends the frame: start bit, BIT_NUM data bits
//   LSB first, then the stop bit. Each bit lasts CLKS_PER_BIT clocks.
//
//   Optional feature: define UART_TX_PARITY_EN to insert an even-parity
//   bit between the last data bit and the stop bit.
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-high reset
//   req      in   [N_REQ]          per-requester transmit request
//   data     in   [N_REQ*BIT_NUM]  packed bytes; requester i at [i*BIT_NUM +: BIT_NUM]
//   grant    out  [N_REQ]          one-hot, 1-cycle pulse when a byte is latched
//   cur_src  out  [log2(N_REQ)]    requester that owns the current or last frame
//   busy     out  high from the grant edge until the stop bit completes
//   tx       out  serial line, idle high
module uart_tx_arbiter #(
    parameter int BIT_NUM      = 8,
    parameter int N_REQ        = 4,
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*BIT_NUM-1:0]   data,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   cur_src,
    output logic                       busy,
    output logic                       tx
);

    localparam int SRC_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int IDX_W = $clog2(BIT_NUM + 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t             state;
    logic [CNT_W-1:0]   baud_cnt;
    logic [IDX_W-1:0]   bit_idx;
    logic [BIT_NUM-1:0] shreg;
    logic [SRC_W-1:0]   last;
    logic [SRC_W-1:0]   sel;
    logic [SRC_W-1:0]   idx;
    logic               any_req;
    logic               bit_done;
`ifdef UART_TX_PARITY_EN
    logic               par_bit;
`endif

    assign bit_done = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Round-robin pick: scan last+1, last+2, ... and take the first set req.
    // N_REQ is a power of two, so truncating the index to SRC_W bits gives
    // the wrap-around. The final step (i == N_REQ) revisits 'last' itself.
    always_comb begin
        sel     = '0;
        idx     = '0;
        any_req = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = last + SRC_W'(i);
            if (!any_req && req[idx]) begin
                sel     = idx;
                any_req = 1'b1;
            end
        end
    end

    // Byte datapath. It has no reset because it is only read after a grant
    // has loaded it.
    always_ff @(posedge clk) begin
        if (state == IDLE && any_req) begin
            shreg   <= data[int'(sel)*BIT_NUM +: BIT_NUM];
`ifdef UART_TX_PARITY_EN
            par_bit <= ^data[int'(sel)*BIT_NUM +: BIT_NUM];
`endif
        end else if (state == DATA && bit_done && bit_idx != IDX_W'(BIT_NUM - 1)) begin
            shreg <= shreg >> 1;
        end
    end

    // Frame sequencer with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            last     <= SRC_W'(N_REQ - 1);
            grant    <= '0;
            cur_src  <= '0;
            busy     <= 1'b0;
            tx       <= 1'b1;
        end else begin
            grant <= '0;
            if (state != IDLE) begin
                baud_cnt <= bit_done ? '0 : baud_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant    <= N_REQ'(1) << sel;
                        cur_src  <= sel;
                        last     <= sel;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        tx      <= shreg[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == IDX_W'(BIT_NUM - 1)) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= par_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            // shreg shifts on this same edge, so the next
                            // bit to send is the one currently at [1].
                            tx      <= shreg[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        busy  <= 1'b0;
                        tx    <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one serial UART transmit line among N_REQ byte requesters.
- Grants one requester at a time, latches its byte, and sequences the frame: start bit, BIT_NUM data bits LSB first, stop bit, all at the baud rate.
- Sits on the transmit side of the serial link, opposite the UART receiver, and uses the same 8N1 frame format at 9600 baud from a 100 MHz clock.

Parameters:
- BIT_NUM, 8, data bits per frame.
- N_REQ, 4, number of requesters; must be ≥2 and a power of 2.
- CLKS_PER_BIT, 10416, clk cycles per serial bit (100_000_000/9600).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester transmit request; held high until the matching grant pulse.
- data  input  N_REQ x BIT_NUM  packed per-requester bytes; data[i] must be valid while req[i] is high.
- grant  output  N_REQ  one-hot, 1-cycle pulse when requester's byte is latched.
- cur_src  output  log2(N_REQ)  index of the requester owning the current or last frame.
- busy  output  1  high from grant edge until stop bit completes.
- tx  output  1  serial line; idle high.

Behaviour:
- Reset values (async, while reset=1):
  - tx=1, busy=0, grant=0, cur_src=0, state=IDLE, bit counter=0, baud counter=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has top priority first.
- States: IDLE, START, DATA, STOP (PARITY added by the optional feature).
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - Wraps at CLKS_PER_BIT-1 and generates bit_done.
  - Forced to 0 on every state entry from IDLE.
- IDLE:
  - On an edge with any req bit set, pick the first set bit scanning last+1, last+2, … modulo N_REQ.
  - On that same edge:
    - shift register ← data[sel]; grant ← onehot(sel); cur_src ← sel; last ← sel;
    - tx ← 0; busy ← 1; state ← START.
  - grant is 0 on every other cycle.
- START: on bit_done, state ← DATA, tx ← shreg[0], bit index ← 0.
- DATA:
  - On bit_done with index < BIT_NUM-1: shift right, tx ← next bit, index+1.
  - On bit_done with index = BIT_NUM-1: tx ← 1, state ← STOP.
- STOP: on bit_done, state ← IDLE, busy ← 0, tx stays 1.
- Timing:
  - Each bit is held exactly CLKS_PER_BIT clocks.
  - A frame lasts (BIT_NUM+2)·CLKS_PER_BIT clocks from the grant edge to busy falling.
- Back-to-back: at least one IDLE cycle follows each frame. With req pending, the next grant comes on the first IDLE edge, so the inter-frame gap of tx high is exactly 1 clk beyond the stop bit.
- req changes during a frame are ignored; arbitration happens only in IDLE.
- A requester that drops req before grant is simply not served. No data is latched and nothing is transmitted for it.
- Simultaneous req from all: served in order last+1, last+2, …, so no requester waits more than N_REQ-1 frames.
- data changes after grant do not affect the frame in flight.
- Reset mid-frame: tx returns high immediately (asynchronously) and the frame is abandoned. The next frame after reset release starts arbitration from requester 0.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP; tx = XOR of the BIT_NUM latched data bits (even parity), held CLKS_PER_BIT clocks.
  - Frame length becomes (BIT_NUM+3)·CLKS_PER_BIT.
- Undefined: no PARITY state; 8N1 frame exactly as in Behaviour.

Test Plan (CLKS_PER_BIT=4, BIT_NUM=8, N_REQ=4):
1. Reset, then req=0001, data[0]=8'hA5 → grant=0001 for 1 clk; tx low 4 clks, then bits 1,0,1,0,0,1,0,1 at 4 clks each, then high 4 clks; busy high for 40 clks; cur_src=0.
2. req=1111 held continuously, distinct bytes 8'h11/22/33/44 → grants in order 0001,0010,0100,1000,0001; each byte's frame correct; exactly 1 idle-high clk between stop bit and next start bit.
3. After serving requester 2, req=0101 → grant goes to requester 0 (scan 3,0,…), then to requester 2.
4. req=0010 asserted mid-frame and then dropped before the frame ends → no grant to requester 1; tx stays high after the frame; busy=0.
5. Assert reset during DATA bit 3 of byte 8'hFF, release 2 clks later → tx=1 and busy=0 immediately; with req=1000 pending, the next grant is 1000 and a full clean frame follows.
6. With UART_TX_PARITY_EN, send 8'h07 → parity bit 1 after data, frame 44 clks. Send 8'h03 → parity bit 0.
